wb_master_bridge: RTL and testbench



---
 rtl/wb_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_wb_master_bridge.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: turns single-word CPU loads/stores into bus cycles,
// with retry back-off, no-response timeout and an init gate.
module wb_master_bridge #(
    parameter int MAX_RETRY = 4,
    parameter int RETRY_GAP = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_sel,
    output logic [31:0] c_rdata,
    output logic        c_done,
    output logic [1:0]  c_status,
    output logic        c_busy,
    output logic [31:0] m_addr,
    output logic [31:0] m_odata,
    output logic [3:0]  m_sel,
    output logic        m_we,
    output logic        m_cyc,
    output logic        m_stb,
    input  logic [31:0] m_idata,
    input  logic        m_ack,
    input  logic        m_err,
    input  logic        m_rty,
    output logic [7:0]  st
);

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST    = 16'(RETRY_GAP - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ERR     = 2'b01;
    localparam logic [1:0] STAT_RTY_EXH = 2'b10;
    localparam logic [1:0] STAT_TMO     = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        RELEASE = 3'd2,
        BACKOFF = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [7:0]  retry_cnt;
    logic [15:0] tmo_cnt;
    logic [15:0] gap_cnt;
    logic        is_retry;
    logic [1:0]  pend_status;
    logic [31:0] pend_rdata;

    logic        accept;
    logic        term;
    logic        tmo_hit;
    logic        gap_hit;
    logic [8:0]  retry_next;
    logic        retry_fail;

    assign accept     = c_req && sdram_init_done;
    assign term       = m_ack || m_err || m_rty;
    assign tmo_hit    = (tmo_cnt >= TMO_LAST);
    assign gap_hit    = (gap_cnt >= GAP_LAST);
    assign retry_next = {1'b0, retry_cnt} + 9'd1;
    assign retry_fail = (retry_next > {1'b0, RETRY_LIMIT});

    // Bus strobes decode straight from the state register so reset drops them at once.
    assign m_cyc  = (state == REQ);
    assign m_stb  = (state == REQ);
    assign c_busy = (state != IDLE);
    assign c_done = (state == DONE);
    assign st     = {5'd0, state};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (term || tmo_hit) state_next = RELEASE;
            RELEASE: if (!term) state_next = is_retry ? BACKOFF : DONE;
            BACKOFF: if (gap_hit) state_next = REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_addr      <= '0;
            m_odata     <= '0;
            m_sel       <= '0;
            m_we        <= 1'b0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            is_retry    <= 1'b0;
            pend_status <= STAT_OK;
            pend_rdata  <= '0;
            c_status    <= STAT_OK;
            c_rdata     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_addr    <= c_addr;
                        m_odata   <= c_wdata;
                        m_sel     <= c_sel;
                        m_we      <= c_we;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        gap_cnt   <= '0;
                        is_retry  <= 1'b0;
                    end
                end
                REQ: begin
                    if (m_ack) begin
                        pend_status <= STAT_OK;
                        pend_rdata  <= m_idata;
                        is_retry    <= 1'b0;
                    end else if (m_err) begin
                        pend_status <= STAT_ERR;
                        is_retry    <= 1'b0;
                    end else if (m_rty) begin
                        retry_cnt <= retry_next[7:0];
                        if (retry_fail) begin
                            pend_status <= STAT_RTY_EXH;
                            is_retry    <= 1'b0;
                        end else begin
                            is_retry <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        pend_status <= STAT_TMO;
                        is_retry    <= 1'b0;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RELEASE: gap_cnt <= '0;
                BACKOFF: begin
                    if (gap_hit) tmo_cnt <= '0;
                    else         gap_cnt <= gap_cnt + 16'd1;
                end
                default: ;
            endcase

            // CPU-visible results only change on the edge that enters DONE.
            if (state == RELEASE && state_next == DONE) begin
                c_status <= pend_status;
                if (pend_status == STAT_OK && !m_we) c_rdata <= pend_rdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: scripted Wishbone responder with a
// word memory, plus a transaction-level reference model of status/rdata/strobes.
module tb_wb_master_bridge;

    localparam int MAX_RETRY = 4;
    localparam int RETRY_GAP = 8;
    localparam int TIMEOUT   = 1024;

    localparam int FIN_NONE   = 0;
    localparam int FIN_ACK    = 1;
    localparam int FIN_ERR    = 2;
    localparam int FIN_ACKERR = 3;

    logic        CLK100MHZ = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_sel;
    logic [31:0] c_rdata;
    logic        c_done;
    logic [1:0]  c_status;
    logic        c_busy;
    logic [31:0] m_addr;
    logic [31:0] m_odata;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        m_cyc;
    logic        m_stb;
    logic [31:0] m_idata;
    logic        m_ack;
    logic        m_err;
    logic        m_rty;
    logic [7:0]  st;

    wb_master_bridge #(
        .MAX_RETRY(MAX_RETRY),
        .RETRY_GAP(RETRY_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK100MHZ      (CLK100MHZ),
        .rst_n          (rst_n),
        .sdram_init_done(sdram_init_done),
        .c_req          (c_req),
        .c_we           (c_we),
        .c_addr         (c_addr),
        .c_wdata        (c_wdata),
        .c_sel          (c_sel),
        .c_rdata        (c_rdata),
        .c_done         (c_done),
        .c_status       (c_status),
        .c_busy         (c_busy),
        .m_addr         (m_addr),
        .m_odata        (m_odata),
        .m_sel          (m_sel),
        .m_we           (m_we),
        .m_cyc          (m_cyc),
        .m_stb          (m_stb),
        .m_idata        (m_idata),
        .m_ack          (m_ack),
        .m_err          (m_err),
        .m_rty          (m_rty),
        .st             (st)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          n_rty;
        int          fin;
        int          wt;
        bit          pulse;
        logic [1:0]  exp_status;
        logic [31:0] exp_rdata;
        int          exp_stb;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder script and bus-side memory
    int          cur_nrty, cur_final, cur_wait, attempt, wait_cnt;
    bit          holding;
    logic [31:0] bus_mem [0:63];

    // Reference model state
    logic [31:0] model_mem [0:63];
    logic [31:0] model_rdata;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] sel);
        c_req   = req;
        c_we    = we;
        c_addr  = addr;
        c_wdata = wdata;
        c_sel   = sel;
    endtask

    task automatic scramble_idle();
        logic [31:0] r;
        r = $urandom();
        applyStimulus(1'b0, r[0], $urandom(), $urandom(), r[7:4]);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input int n_rty, input int fin, input int wt,
                                input bit pulse, input logic [1:0] es, input logic [31:0] er, input int estb);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.n_rty = n_rty; v.fin = fin; v.wt = wt; v.pulse = pulse;
        v.exp_status = es; v.exp_rdata = er; v.exp_stb = estb;
        return v;
    endfunction

    // Transaction-level prediction: outcome from the rty count and final answer,
    // memory effects applied only for successful transfers.
    function automatic void predict(input vec_t v, output logic [1:0] s, output logic [31:0] rd, output int nstb);
        logic [5:0] idx;
        idx = v.addr[7:2];
        if (v.n_rty > MAX_RETRY) begin
            s    = 2'b10;
            nstb = MAX_RETRY + 1;
        end else begin
            nstb = v.n_rty + 1;
            case (v.fin)
                FIN_NONE: s = 2'b11;
                FIN_ERR:  s = 2'b01;
                default:  s = 2'b00;
            endcase
        end
        if (s == 2'b00) begin
            if (v.we) begin
                for (int b = 0; b < 4; b++)
                    if (v.sel[b]) model_mem[idx][8*b +: 8] = v.wdata[8*b +: 8];
            end else begin
                model_rdata = model_mem[idx];
            end
        end
        rd = model_rdata;
    endfunction

    // Scripted responder: waits cur_wait cycles of stb, answers rty cur_nrty times
    // then the final answer, and holds the answer until it sees stb low.
    initial begin
        logic [5:0] ridx;
        int         kind;
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; m_idata = '0;
        holding = 1'b0; wait_cnt = 0; attempt = 0;
        forever begin
            @(negedge CLK100MHZ);
            if (!rst_n) begin
                m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
                holding = 1'b0; wait_cnt = 0;
            end else if (holding) begin
                if (!m_stb) begin
                    m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
                    m_idata = $urandom();
                    holding = 1'b0;
                end
            end else if (m_stb) begin
                if (wait_cnt < cur_wait) begin
                    wait_cnt++;
                end else begin
                    kind = (attempt < cur_nrty) ? -1 : cur_final;
                    ridx = m_addr[7:2];
                    if (kind == -1) begin
                        m_rty = 1'b1;
                    end else if (kind == FIN_ERR) begin
                        m_err = 1'b1;
                    end else if (kind == FIN_ACK || kind == FIN_ACKERR) begin
                        m_ack = 1'b1;
                        m_err = (kind == FIN_ACKERR);
                        if (m_we) begin
                            for (int b = 0; b < 4; b++)
                                if (m_sel[b]) bus_mem[ridx][8*b +: 8] = m_odata[8*b +: 8];
                        end else begin
                            m_idata = bus_mem[ridx];
                        end
                    end
                    if (kind != FIN_NONE) begin
                        holding = 1'b1;
                        attempt++;
                        wait_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic run_txn(input vec_t v, input logic [1:0] es, input logic [31:0] er, input int estb);
        int cyc, stb_cnt, low_run, min_gap, high_run, last_high, budget;
        bit prev_stb, hold_ok, done_seen;
        logic [31:0] r;
        cur_nrty = v.n_rty; cur_final = v.fin; cur_wait = v.wt;
        attempt = 0; wait_cnt = 0;
        budget = (MAX_RETRY + 2) * (TIMEOUT + RETRY_GAP + v.wt + 8) + 20;

        applyStimulus(1'b1, v.we, v.addr, v.wdata, v.sel);
        @(negedge CLK100MHZ);
        scramble_idle();
        checkOutput("cyc_rise", 32'(m_cyc), 32'd1);
        hold_ok  = (m_addr === v.addr) && (m_odata === v.wdata) && (m_sel === v.sel) && (m_we === v.we);
        stb_cnt  = m_stb ? 1 : 0;
        prev_stb = m_stb;
        high_run = 1; last_high = 0; low_run = 0; min_gap = 1000000;
        done_seen = 1'b0;

        for (cyc = 0; cyc < budget && !done_seen; cyc++) begin
            if (v.pulse && cyc == 1) begin
                r = $urandom();
                applyStimulus(1'b1, r[0], $urandom(), $urandom(), r[7:4]);
            end else if (v.pulse && cyc == 2) begin
                scramble_idle();
            end
            @(negedge CLK100MHZ);
            if (m_stb) begin
                if (!prev_stb) begin
                    stb_cnt++;
                    if (low_run < min_gap) min_gap = low_run;
                    high_run = 1;
                end else begin
                    high_run++;
                end
                low_run = 0;
                if (!((m_addr === v.addr) && (m_odata === v.wdata) && (m_sel === v.sel) && (m_we === v.we)))
                    hold_ok = 1'b0;
            end else begin
                if (prev_stb) last_high = high_run;
                low_run++;
            end
            prev_stb = m_stb;
            if (c_done) done_seen = 1'b1;
        end
        scramble_idle();

        checkOutput("done_seen", 32'(done_seen), 32'd1);
        if (done_seen) begin
            checkOutput("status", 32'(c_status), 32'(es));
            checkOutput("rdata", c_rdata, er);
            checkOutput("busy_in_done", 32'(c_busy), 32'd1);
            checkOutput("stb_count", 32'(stb_cnt), 32'(estb));
            checkOutput("bus_hold", 32'(hold_ok), 32'd1);
            if (estb > 1) checkOutput("retry_gap", 32'(min_gap >= RETRY_GAP), 32'd1);
            if (es == 2'b11) checkOutput("timeout_len", 32'(last_high), 32'(TIMEOUT));
        end
        @(negedge CLK100MHZ);
        checkOutput("done_pulse", 32'(c_done), 32'd0);
        checkOutput("idle_after", 32'(c_busy), 32'd0);
        checkOutput("st_idle", 32'(st), 32'd0);
        if (v.pulse) begin
            @(negedge CLK100MHZ);
            checkOutput("pulse_ignored", 32'(m_cyc), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no end expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl [12];
        vec_t        v;
        logic [1:0]  ps;
        logic [31:0] pr, r;
        int          pstb;
        bit          gate_ok, done_any;

        for (int i = 0; i < 64; i++) begin
            bus_mem[i]   = '0;
            model_mem[i] = '0;
        end
        bus_mem[4]   = 32'hDEADBEEF;
        model_mem[4] = 32'hDEADBEEF;
        model_rdata  = '0;
        cur_nrty = 0; cur_final = FIN_ACK; cur_wait = 0;

        tbl[0]  = mk(0, 32'h10, 32'h0,        4'hF, 0, FIN_ACK,    1, 0, 2'b00, 32'hDEADBEEF, 1);
        tbl[1]  = mk(1, 32'h20, 32'h11223344, 4'h5, 0, FIN_ACK,    0, 0, 2'b00, 32'hDEADBEEF, 1);
        tbl[2]  = mk(0, 32'h20, 32'h0,        4'hF, 0, FIN_ACK,    0, 0, 2'b00, 32'h00220044, 1);
        tbl[3]  = mk(0, 32'h10, 32'h0,        4'hF, 3, FIN_ACK,    0, 1, 2'b00, 32'hDEADBEEF, 4);
        tbl[4]  = mk(0, 32'h20, 32'h0,        4'hF, 5, FIN_ACK,    0, 0, 2'b10, 32'hDEADBEEF, 5);
        tbl[5]  = mk(0, 32'h20, 32'h0,        4'hF, 0, FIN_ERR,    0, 0, 2'b01, 32'hDEADBEEF, 1);
        tbl[6]  = mk(0, 32'h20, 32'h0,        4'hF, 0, FIN_ACKERR, 0, 0, 2'b00, 32'h00220044, 1);
        tbl[7]  = mk(1, 32'h10, 32'hCAFEF00D, 4'hF, 0, FIN_ERR,    2, 0, 2'b01, 32'h00220044, 1);
        tbl[8]  = mk(0, 32'h10, 32'h0,        4'hF, 0, FIN_ACK,    0, 0, 2'b00, 32'hDEADBEEF, 1);
        tbl[9]  = mk(0, 32'h30, 32'h0,        4'hF, 0, FIN_NONE,   0, 0, 2'b11, 32'hDEADBEEF, 1);
        tbl[10] = mk(1, 32'h30, 32'hAABBCCDD, 4'h8, 1, FIN_ACK,    2, 0, 2'b00, 32'hDEADBEEF, 2);
        tbl[11] = mk(0, 32'h30, 32'h0,        4'hF, 0, FIN_ACK,    0, 0, 2'b00, 32'hAA000000, 1);

        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge CLK100MHZ);
        checkOutput("rst_cyc",    32'(m_cyc),    32'd0);
        checkOutput("rst_stb",    32'(m_stb),    32'd0);
        checkOutput("rst_we",     32'(m_we),     32'd0);
        checkOutput("rst_done",   32'(c_done),   32'd0);
        checkOutput("rst_busy",   32'(c_busy),   32'd0);
        checkOutput("rst_addr",   m_addr,        32'd0);
        checkOutput("rst_odata",  m_odata,       32'd0);
        checkOutput("rst_rdata",  c_rdata,       32'd0);
        checkOutput("rst_sel",    32'(m_sel),    32'd0);
        checkOutput("rst_status", 32'(c_status), 32'd0);
        checkOutput("rst_st",     32'(st),       32'd0);
        rst_n = 1'b1;

        // Init gate: request held while memory is not ready must not start a cycle
        applyStimulus(1'b1, 1'b0, 32'h10, '0, 4'hF);
        gate_ok = 1'b1;
        repeat (6) begin
            @(negedge CLK100MHZ);
            if (m_cyc || c_busy) gate_ok = 1'b0;
        end
        checkOutput("init_gate", 32'(gate_ok), 32'd1);
        sdram_init_done = 1'b1;
        v = mk(0, 32'h10, 32'h0, 4'hF, 0, FIN_ACK, 0, 0, 2'b00, 32'h0, 1);
        predict(v, ps, pr, pstb);
        run_txn(v, ps, pr, pstb);

        for (int i = 0; i < 12; i++) begin
            predict(tbl[i], ps, pr, pstb);
            run_txn(tbl[i], tbl[i].exp_status, tbl[i].exp_rdata, tbl[i].exp_stb);
        end

        // Reset in the middle of an outstanding request
        cur_nrty = 0; cur_final = FIN_NONE; cur_wait = 0; attempt = 0; wait_cnt = 0;
        applyStimulus(1'b1, 1'b0, 32'h10, '0, 4'hF);
        @(negedge CLK100MHZ);
        scramble_idle();
        repeat (4) @(negedge CLK100MHZ);
        checkOutput("pre_rst_cyc", 32'(m_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_cyc",  32'(m_cyc),  32'd0);
        checkOutput("async_stb",  32'(m_stb),  32'd0);
        checkOutput("async_busy", 32'(c_busy), 32'd0);
        done_any = 1'b0;
        repeat (3) begin
            @(negedge CLK100MHZ);
            if (c_done) done_any = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge CLK100MHZ);
            if (c_done || m_cyc) done_any = 1'b1;
        end
        checkOutput("no_done_after_rst", 32'(done_any), 32'd0);
        checkOutput("rst_rdata2", c_rdata, 32'd0);
        model_rdata = '0;
        v = mk(0, 32'h10, 32'h0, 4'hF, 0, FIN_ACK, 1, 0, 2'b00, 32'h0, 1);
        predict(v, ps, pr, pstb);
        checkOutput("model_after_rst", pr, 32'hDEADBEEF);
        run_txn(v, ps, pr, pstb);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            int pick;
            r = $urandom();
            v.we    = r[0];
            v.addr  = {r[31:8], 6'($urandom_range(0, 63)), 2'b00};
            v.wdata = $urandom();
            v.sel   = r[7:4];
            v.n_rty = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 6));
            pick    = int'($urandom_range(0, 99));
            v.fin   = (pick < 3) ? FIN_NONE : (pick < 18) ? FIN_ERR : (pick < 28) ? FIN_ACKERR : FIN_ACK;
            v.wt    = int'($urandom_range(0, 3));
            v.pulse = r[1];
            predict(v, ps, pr, pstb);
            run_txn(v, ps, pr, pstb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
